shift_counter: RTL and testbench
================================

# shift_counter

Parametrised shift-register counter: the next generation of our fixed 4-bit Johnson counter. Supports any width, Johnson or ring sequencing selected at run time, count enable, up/down direction, parallel load, a decoded state index, and a wrap pulse. Used as a cheap glitch-free phase/sequence generator feeding decode logic, with illegal-state detection for robustness.

## Interface

**Parameters**
- `WIDTH`, default 4: number of flops. Legal range ≥ 2.
- `IDX_W`, default `$clog2(2*WIDTH)`: width of the state index. Derived; do not override.

**Ports**
- `clk` input, 1 bit: sole clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: count enable; one step per cycle while high.
- `dir` input, 1 bit: 0 = up (shift toward MSB), 1 = down (shift toward LSB).
- `mode` input, 1 bit: 0 = Johnson (period 2·WIDTH), 1 = ring (period WIDTH).
- `load` input, 1 bit: parallel load strobe.
- `load_val` input, WIDTH bits: value captured on `load`.
- `q` output, WIDTH bits: counter state (registered).
- `idx` output, IDX_W bits: position of `q` in the current sequence. Combinational from `q` and `mode`.
- `wrap` output, 1 bit: registered one-cycle pulse.
- `illegal` output, 1 bit: combinational; `q` is not a legal code for the current `mode`.

## Operation

- **Reset:** `q` = all zeros if `mode`=0, else `{0..0,1}` (mode sampled in the reset cycle). `wrap`=0.
- **Priority per cycle:** `rst` > `load` > self-correct (see Configuration) > `en` step > hold.
- **Johnson step:**
  - up: `q <= {q[W-2:0], ~q[W-1]}`
  - down: `q <= {~q[0], q[W-1:1]}`
- **Ring step:**
  - up: `q <= {q[W-2:0], q[W-1]}`
  - down: `q <= {q[0], q[W-1:1]}`
- **Legal codes:**
  - Johnson: contiguous ones anchored at the LSB (`0..01..1`) or at the MSB (`1..10..0`), including all-zeros and all-ones.
  - Ring: exactly one bit set.
- **idx:**
  - Johnson: popcount(q) if `q[W-1]`=0, else 2·WIDTH − popcount(q). So 0000→0, 1111→4, 1000→7 at W=4.
  - Ring: bit position of the set bit.
  - `idx` is don't-care while `illegal`=1.
- **wrap:** asserted the cycle after an `en` step that moves `idx` from LAST to 0 (up) or from 0 to LAST (down), where LAST = period−1. Load and reset never raise `wrap`.
- **Load:** `load_val` is taken verbatim, even if illegal.
- **Mode change mid-run:** `q` is kept as-is. If it is illegal under the new mode, `illegal` rises immediately.

## Timing

- `q` updates one cycle after the qualifying input (`en`, `load`, `rst`).
- `idx` and `illegal` follow `q` with zero added latency.
- `wrap` is coincident with the `q` value it refers to.
- `en` held high gives full throughput: one step per clock, no bubbles.
- `rst` during count or load: the next `q` is the reset value and `wrap`=0, regardless of `en` or `load`.
- `load` and `en` in the same cycle: load wins and no step occurs.

## Configuration

- **`SHIFT_COUNTER_SELFCORRECT_EN` defined:** in any cycle with `illegal`=1 and no `rst`/`load`, the next `q` is the mode's start code (zeros for Johnson, `{0..0,1}` for ring), independent of `en`. `wrap` stays 0. Recovery takes 1 cycle.
- **Not defined:** illegal states are stepped or held like any other value. `illegal` still flags them; there is no recovery except via `load` or `rst`.

## Structure

- **Package `shift_counter_pkg`:**
  - mode constants `MODE_JOHNSON`=1'b0 and `MODE_RING`=1'b1
  - direction constants `DIR_UP`=1'b0 and `DIR_DOWN`=1'b1
  - period function `period(width, mode)`
- **Sub-module `shift_counter_decode`:** purely combinational; `q`, `mode` → `idx`, `illegal`, `at_last`, `at_first`. It is instantiated once in the top. Next-state logic and the `wrap` register stay in the top.

## Test plan

All scenarios use WIDTH=4.

1. **Johnson up wrap:** `rst`, `mode`=0, `en`=1, `dir`=0 for 8 cycles → `q` = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; `idx` = 1..7, 0; `wrap`=1 only with the final 0000.
2. **Johnson down:** from 0000, `dir`=1, `en`=1 → `q` = 1000 with `idx`=7 and `wrap`=1, then 1100 with `idx`=6 and `wrap`=0.
3. **Ring mode:** `rst` with `mode`=1 → `q`=0001. Up 4 steps → 0010, 0100, 1000, 0001; `wrap` only on 0001. `en`=0 for 3 cycles → `q` holds.
4. **Illegal load:** `load`=1, `load_val`=0101, `mode`=0, `en`=0 → `q`=0101 and `illegal`=1.
   - With the macro: next cycle `q`=0000, `illegal`=0, `wrap`=0.
   - Without the macro: `q` stays 0101 and `illegal` stays 1.
5. **Reset priority:** mid-count at 0111 with `rst`=`load`=`en`=1 → next `q`=0000, `wrap`=0. Then `load`=`en`=1 with `load_val`=0011 → `q`=0011 (no step).
6. **Mode switch:** at Johnson 0011, set `mode`=1 → `illegal`=1 the same cycle.
   - With the macro: next `q`=0001.
   - Without the macro: the ring step gives 0110, still illegal.

Source files
------------

// File: rtl/shift_counter_pkg.sv
// ============================================================================
// Module   : shift_counter_pkg
// Purpose  : Shared mode/direction encodings and sequence-period helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_counter_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    function automatic int period(input int width, input logic mode);
        return (mode == MODE_RING) ? width : 2 * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/shift_counter_decode.sv
// ============================================================================
// Module   : shift_counter_decode
// Purpose  : Combinational decode of counter state into index, legality and
//            first/last-position flags for the current mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_counter_decode
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             mode,
    output logic [IDX_W-1:0] idx,
    output logic             illegal,
    output logic             at_last,
    output logic             at_first
);

    logic [IDX_W-1:0] w_pop;
    logic [IDX_W-1:0] w_ring_idx;
    logic [IDX_W-1:0] w_last;
    logic [WIDTH-1:0] w_q_inc;
    logic [WIDTH-1:0] w_nq;
    logic [WIDTH-1:0] w_nq_inc;
    logic [WIDTH-1:0] w_q_dec;
    logic             w_legal_j;
    logic             w_legal_r;

    always_comb begin
        w_pop      = '0;
        w_ring_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_pop = w_pop + {{(IDX_W-1){1'b0}}, q[i]};
            if (q[i]) begin
                w_ring_idx = IDX_W'(i);
            end
        end
    end

    // A 0..01..1 code plus one is a power of two (or wraps to zero), so
    // ANDing with it clears everything; the MSB-anchored form is its inverse.
    assign w_q_inc   = q + WIDTH'(1);
    assign w_nq      = ~q;
    assign w_nq_inc  = w_nq + WIDTH'(1);
    assign w_q_dec   = q - WIDTH'(1);
    assign w_legal_j = ((q & w_q_inc) == '0) || ((w_nq & w_nq_inc) == '0);
    assign w_legal_r = (q != '0) && ((q & w_q_dec) == '0);

    assign illegal = (mode == MODE_RING) ? ~w_legal_r : ~w_legal_j;

    // Modular subtraction yields 2*WIDTH - popcount even when 2*WIDTH
    // itself does not fit in IDX_W bits.
    assign idx = (mode == MODE_RING) ? w_ring_idx
               : (q[WIDTH-1] ? (IDX_W'(2 * WIDTH) - w_pop) : w_pop);

    assign w_last   = IDX_W'(period(WIDTH, mode) - 1);
    assign at_last  = ~illegal && (idx == w_last);
    assign at_first = ~illegal && (idx == '0);

endmodule

`default_nettype wire

// File: rtl/shift_counter.sv
// ============================================================================
// Module   : shift_counter
// Purpose  : Parametrised Johnson/ring shift counter with load, direction,
//            decoded index and wrap pulse. Optional illegal-state recovery
//            enabled by defining SHIFT_COUNTER_SELFCORRECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_counter
    import shift_counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [IDX_W-1:0] idx,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_start;
    logic             w_wrap_next;
    logic             w_fb_up;
    logic             w_fb_dn;
    logic             w_at_last;
    logic             w_at_first;
    logic             w_correct;

    shift_counter_decode #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_decode (
        .q        (r_q),
        .mode     (mode),
        .idx      (idx),
        .illegal  (illegal),
        .at_last  (w_at_last),
        .at_first (w_at_first)
    );

    assign w_start = (mode == MODE_RING) ? WIDTH'(1) : '0;

    // Ring recirculates the outgoing bit; Johnson inverts it.
    assign w_fb_up = (mode == MODE_RING) ? r_q[WIDTH-1] : ~r_q[WIDTH-1];
    assign w_fb_dn = (mode == MODE_RING) ? r_q[0]       : ~r_q[0];

`ifdef SHIFT_COUNTER_SELFCORRECT_EN
    assign w_correct = illegal;
`else
    assign w_correct = 1'b0;
`endif

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next = load_val;
        end else if (w_correct) begin
            w_q_next = w_start;
        end else if (en) begin
            if (dir == DIR_UP) begin
                w_q_next    = {r_q[WIDTH-2:0], w_fb_up};
                w_wrap_next = w_at_last;
            end else begin
                w_q_next    = {w_fb_dn, r_q[WIDTH-1:1]};
                w_wrap_next = w_at_first;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= w_start;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign q    = r_q;
    assign wrap = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_shift_counter.sv
// ============================================================================
// Module   : tb_shift_counter
// Purpose  : Directed self-checking bench for shift_counter at WIDTH=4.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dir;
    logic       mode;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic [2:0] idx;
    logic       wrap;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

    shift_counter #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .idx      (idx),
        .wrap     (wrap),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_q  [8];
    logic [2:0] exp_i  [8];

    initial begin
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; load_val = 4'h0;
        step();
        check("reset_q", 32'(q), 32'h0);
        check("reset_wrap", 32'(wrap), 32'h0);
        check("reset_idx", 32'(idx), 32'h0);
        check("reset_illegal", 32'(illegal), 32'h0);

        // Johnson up through a full period
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        exp_i = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("j_up_q%0d", i), 32'(q), 32'(exp_q[i]));
            check($sformatf("j_up_idx%0d", i), 32'(idx), 32'(exp_i[i]));
            check($sformatf("j_up_wrap%0d", i), 32'(wrap), (i == 7) ? 32'h1 : 32'h0);
        end

        // Johnson down from 0000
        dir = 1'b1;
        step();
        check("j_dn_q0", 32'(q), 32'b1000);
        check("j_dn_idx0", 32'(idx), 32'd7);
        check("j_dn_wrap0", 32'(wrap), 32'h1);
        step();
        check("j_dn_q1", 32'(q), 32'b1100);
        check("j_dn_idx1", 32'(idx), 32'd6);
        check("j_dn_wrap1", 32'(wrap), 32'h0);

        // Ring mode
        rst = 1'b1; mode = 1'b1; en = 1'b0; dir = 1'b0;
        step();
        check("r_reset_q", 32'(q), 32'b0001);
        check("r_reset_illegal", 32'(illegal), 32'h0);
        rst = 1'b0; en = 1'b1;
        exp_q[0] = 4'b0010; exp_q[1] = 4'b0100; exp_q[2] = 4'b1000; exp_q[3] = 4'b0001;
        exp_i[0] = 3'd1;    exp_i[1] = 3'd2;    exp_i[2] = 3'd3;    exp_i[3] = 3'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("r_up_q%0d", i), 32'(q), 32'(exp_q[i]));
            check($sformatf("r_up_idx%0d", i), 32'(idx), 32'(exp_i[i]));
            check($sformatf("r_up_wrap%0d", i), 32'(wrap), (i == 3) ? 32'h1 : 32'h0);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("r_hold_q%0d", i), 32'(q), 32'b0001);
            check($sformatf("r_hold_wrap%0d", i), 32'(wrap), 32'h0);
        end

        // Illegal load in Johnson mode
        mode = 1'b0; load = 1'b1; load_val = 4'b0101;
        step();
        check("ill_load_q", 32'(q), 32'b0101);
        check("ill_load_illegal", 32'(illegal), 32'h1);
        load = 1'b0;
        step();
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
        check("ill_fix_q", 32'(q), 32'b0000);
        check("ill_fix_illegal", 32'(illegal), 32'h0);
        check("ill_fix_wrap", 32'(wrap), 32'h0);
`else
        check("ill_hold_q", 32'(q), 32'b0101);
        check("ill_hold_illegal", 32'(illegal), 32'h1);
        check("ill_hold_wrap", 32'(wrap), 32'h0);
`endif

        // Reset priority over load and enable
        rst = 1'b1;
        step();
        rst = 1'b0; en = 1'b1; dir = 1'b0;
        step(); step(); step();
        check("pri_mid_q", 32'(q), 32'b0111);
        rst = 1'b1; load = 1'b1; load_val = 4'b1010;
        step();
        check("pri_rst_q", 32'(q), 32'b0000);
        check("pri_rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b0; load_val = 4'b0011;
        step();
        check("pri_load_q", 32'(q), 32'b0011);

        // Load of the last code never raises wrap; the following step does
        load_val = 4'b1000;
        step();
        check("load_last_q", 32'(q), 32'b1000);
        check("load_last_wrap", 32'(wrap), 32'h0);
        load = 1'b0;
        step();
        check("after_load_q", 32'(q), 32'b0000);
        check("after_load_wrap", 32'(wrap), 32'h1);

        // Mode switch from Johnson 0011 into ring
        load = 1'b1; en = 1'b0; load_val = 4'b0011;
        step();
        load = 1'b0;
        check("sw_pre_illegal", 32'(illegal), 32'h0);
        mode = 1'b1;
        #1;
        check("sw_illegal_now", 32'(illegal), 32'h1);
        en = 1'b1;
        step();
`ifdef SHIFT_COUNTER_SELFCORRECT_EN
        check("sw_fix_q", 32'(q), 32'b0001);
        check("sw_fix_illegal", 32'(illegal), 32'h0);
`else
        check("sw_step_q", 32'(q), 32'b0110);
        check("sw_step_illegal", 32'(illegal), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
